// File: rtl/st_mchan_fifo_arbiter.sv
// Multi-channel Avalon-ST merger: one synchronous FIFO per input channel, round-robin
// arbitration into a single registered output slot tagged with the source channel.
module st_mchan_fifo_arbiter #(
    parameter int DATA_W      = 32,
    parameter int CHANNELS    = 2,
    parameter int DEPTH       = 16,
    parameter int ALMOST_FULL = 12,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic                       clk_100_clk,
    input  logic                       reset_reset_n,
    input  logic [CHANNELS*DATA_W-1:0] in_data,
    input  logic [CHANNELS-1:0]        in_valid,
    output logic [CHANNELS-1:0]        in_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [CH_W-1:0]            out_channel,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic [CHANNELS-1:0]        channel_en,
    output logic [CHANNELS*LVL_W-1:0]  fill_level,
    output logic [CHANNELS-1:0]        almost_full
);

    localparam int PTR_W = LVL_W - 1;

    logic [DATA_W-1:0]   mem_q      [CHANNELS][DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q   [CHANNELS];
    logic [PTR_W-1:0]    rd_ptr_q   [CHANNELS];
    logic [LVL_W-1:0]    count_q    [CHANNELS];
    logic [LVL_W-1:0]    count_d    [CHANNELS];
    logic [CHANNELS-1:0] in_ready_q;
    logic [CHANNELS-1:0] almost_full_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [CH_W-1:0]     out_channel_q;
    logic                out_valid_q;
    logic [CH_W-1:0]     last_grant_q;

    logic [CHANNELS-1:0] push;
    logic [CHANNELS-1:0] pop;
    logic [CHANNELS-1:0] eligible;
    logic                slot_free;
    logic                grant_vld;
    logic [CH_W-1:0]     grant_idx;

    assign slot_free = !out_valid_q || out_ready;

    always_comb begin
        push     = '0;
        eligible = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            push[i]     = in_valid[i] & in_ready_q[i];
            eligible[i] = (count_q[i] != '0) & channel_en[i];
        end
    end

    // Scan cyclically starting just after the last winner; first eligible channel wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned off = 1; off <= CHANNELS; off++) begin
            int unsigned idx;
            idx = 32'(last_grant_q) + off;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (!grant_vld && eligible[idx]) begin
                grant_vld = 1'b1;
                grant_idx = CH_W'(idx);
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int unsigned j = 0; j < CHANNELS; j++) begin
            pop[j] = slot_free && grant_vld && (grant_idx == CH_W'(j));
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            count_d[i] = count_q[i] + LVL_W'(push[i]) - LVL_W'(pop[i]);
        end
    end

    // Storage carries no reset; validity is tracked solely by the pointers and counts.
    always_ff @(posedge clk_100_clk) begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_100_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            in_ready_q    <= '1;
            almost_full_q <= '0;
            out_data_q    <= '0;
            out_channel_q <= '0;
            out_valid_q   <= 1'b0;
            last_grant_q  <= CH_W'(CHANNELS - 1);
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (push[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
                end
                count_q[i]       <= count_d[i];
                // Ready derives from the next count only, so a same-cycle pop never
                // re-opens a full FIFO before the following cycle.
                in_ready_q[i]    <= (count_d[i] != LVL_W'(DEPTH));
                almost_full_q[i] <= (count_d[i] >= LVL_W'(ALMOST_FULL));
            end
            if (slot_free) begin
                if (grant_vld) begin
                    out_valid_q   <= 1'b1;
                    out_data_q    <= mem_q[grant_idx][rd_ptr_q[grant_idx]];
                    out_channel_q <= grant_idx;
                    last_grant_q  <= grant_idx;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        fill_level = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            fill_level[i*LVL_W +: LVL_W] = count_q[i];
        end
    end

    assign in_ready    = in_ready_q;
    assign almost_full = almost_full_q;
    assign out_data    = out_data_q;
    assign out_channel = out_channel_q;
    assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_st_mchan_fifo_arbiter.sv
// Scoreboard bench for st_mchan_fifo_arbiter: stimulus queues expected words,
// an independent monitor pops and compares on every accepted output transfer.
module tb_st_mchan_fifo_arbiter;

    localparam int DW  = 32;
    localparam int CH  = 2;
    localparam int DEP = 16;
    localparam int AF  = 12;
    localparam int LW  = 5;
    localparam int CW  = 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CH*DW-1:0] in_data;
    logic [CH-1:0]    in_valid;
    logic [CH-1:0]    in_ready;
    logic [DW-1:0]    out_data;
    logic [CW-1:0]    out_channel;
    logic             out_valid;
    logic             out_ready;
    logic [CH-1:0]    channel_en;
    logic [CH*LW-1:0] fill_level;
    logic [CH-1:0]    almost_full;

    always #5 clk = ~clk;

    st_mchan_fifo_arbiter #(
        .DATA_W(DW), .CHANNELS(CH), .DEPTH(DEP), .ALMOST_FULL(AF)
    ) dut (
        .clk_100_clk  (clk),
        .reset_reset_n(rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_channel  (out_channel),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .channel_en   (channel_en),
        .fill_level   (fill_level),
        .almost_full  (almost_full)
    );

    typedef struct {
        logic [CW-1:0] ch;
        logic [DW-1:0] d;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got ch=%0d data=%h, required no output", out_channel, out_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_data !== mon_e.d || out_channel !== mon_e.ch) begin
                    errors++;
                    $display("FAIL out_word: got ch=%0d data=%h, required ch=%0d data=%h",
                             out_channel, out_data, mon_e.ch, mon_e.d);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [CW-1:0] ch, input logic [DW-1:0] d);
        exp_t e;
        e.ch = ch;
        e.d  = d;
        exp_q.push_back(e);
    endtask

    function automatic logic [LW-1:0] fill(input int ch);
        return fill_level[ch*LW +: LW];
    endfunction

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drain(input string name, input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) tick();
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_data    = '0;
        in_valid   = '0;
        out_ready  = 1'b0;
        channel_en = 2'b11;

        // 1: reset with random inputs
        for (int i = 0; i < 5; i++) begin
            in_data   = {$urandom, $urandom};
            in_valid  = CH'($urandom_range(0, 3));
            out_ready = 1'($urandom_range(0, 1));
            tick();
            chk("rst_out_valid", 64'(out_valid), 64'd0);
        end
        chk("rst_in_ready", 64'(in_ready), 64'h3);
        chk("rst_fill_level", 64'(fill_level), 64'd0);
        chk("rst_almost_full", 64'(almost_full), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_channel", 64'(out_channel), 64'd0);
        in_valid  = '0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        tick();

        // 2: single word latency
        in_data[DW-1:0] = 32'hCAFE0001;
        in_valid        = 2'b01;
        expect_word(1'b0, 32'hCAFE0001);
        tick();
        in_valid = '0;
        chk("t2_valid_after_push", 64'(out_valid), 64'd0);
        chk("t2_fill_after_push", 64'(fill(0)), 64'd1);
        tick();
        chk("t2_valid_next_edge", 64'(out_valid), 64'd1);
        chk("t2_fill_after_pop", 64'(fill(0)), 64'd0);
        tick();
        chk("t2_idle", 64'(out_valid), 64'd0);
        drain("t2_drain", 5);

        // 3: round-robin fairness
        do_reset();
        for (int i = 0; i < 8; i++) begin
            expect_word(1'b0, 32'hA000_0000 + 32'(i));
            expect_word(1'b1, 32'hB000_0000 + 32'(i));
        end
        fork
            begin
                int ia = 0;
                int ib = 0;
                logic [1:0] acc;
                for (int c = 0; c < 40 && (ia < 8 || ib < 8); c++) begin
                    in_valid[0]       = (ia < 8);
                    in_valid[1]       = (ib < 8);
                    in_data[DW-1:0]   = 32'hA000_0000 + 32'(ia);
                    in_data[2*DW-1:DW] = 32'hB000_0000 + 32'(ib);
                    acc = in_valid & in_ready;
                    tick();
                    ia += int'(acc[0]);
                    ib += int'(acc[1]);
                end
                in_valid = '0;
            end
            begin
                int run = 0;
                int w   = 0;
                while (out_valid !== 1'b1 && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                while (out_valid === 1'b1 && run < 40) begin
                    run++;
                    @(negedge clk);
                end
                chk("t3_consecutive_valid", 64'(run), 64'd16);
            end
        join
        drain("t3_drain", 10);

        // 4: fill channel 1 behind a stalled output
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) expect_word(1'b1, 32'hC000_0000 + 32'(i));
        begin
            int n = 0;
            int exp_fill;
            logic acc;
            for (int c = 0; c < 40 && n < 17; c++) begin
                in_valid           = 2'b10;
                in_data[2*DW-1:DW] = 32'hC000_0000 + 32'(n);
                acc = in_ready[1];
                tick();
                if (acc) n++;
                exp_fill = (n <= 1) ? n : n - 1;
                chk("t4_fill", 64'(fill(1)), 64'(exp_fill));
                chk("t4_almost_full", 64'(almost_full[1]), 64'(exp_fill >= AF));
            end
            chk("t4_accepted", 64'(n), 64'd17);
        end
        chk("t4_in_ready_full", 64'(in_ready[1]), 64'd0);
        chk("t4_out_valid", 64'(out_valid), 64'd1);
        in_data[2*DW-1:DW] = 32'hDEAD_BEEF;
        tick();
        tick();
        chk("t4_still_blocked", 64'(in_ready[1]), 64'd0);
        in_valid  = '0;
        out_ready = 1'b1;
        drain("t4_drain", 60);
        chk("t4_fill_empty", 64'(fill(1)), 64'd0);

        // 5: disabled channel holds its words
        channel_en = 2'b01;
        for (int i = 0; i < 3; i++) begin
            in_valid           = 2'b10;
            in_data[2*DW-1:DW] = 32'hD000_0000 + 32'(i);
            expect_word(1'b1, 32'hD000_0000 + 32'(i));
            tick();
        end
        in_valid = '0;
        repeat (5) tick();
        chk("t5_not_granted", 64'(out_valid), 64'd0);
        chk("t5_fill_held", 64'(fill(1)), 64'd3);
        channel_en = 2'b11;
        drain("t5_drain", 20);

        // 6: reset while busy
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid        = 2'b01;
            in_data[DW-1:0] = 32'hE000_0000 + 32'(i);
            tick();
        end
        in_valid = '0;
        chk("t6_fill_before", 64'(fill(0)), 64'd5);
        chk("t6_valid_before", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid_async", 64'(out_valid), 64'd0);
        tick();
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (10) tick();
        chk("t6_fill_after", 64'(fill(0)), 64'd0);
        chk("t6_no_stale", 64'(out_valid), 64'd0);

        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
